// File: rtl/bus_seq_pkg.sv
// rtl/bus_seq_pkg.sv - shared types and defaults for the multiplexed bus sequencer
package bus_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;
    localparam int unsigned DEFAULT_CNT_WIDTH      = 5;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter; bit 0 = IF, bit 1 = DM
module rr_arb2
    import bus_seq_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    // Pointer holds the owner granted last; reset to IF so DM wins the first tie.
    owner_e last_q;
    owner_e last_d;

    // Grant decode: a lone requester wins, a tie goes to whoever was not granted last.
    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_q == OWN_DM) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        if (update && (gnt != 2'b00)) begin
            last_d = gnt[1] ? OWN_DM : OWN_IF;
        end
    end

    // Pointer register, moved only when a grant is actually taken.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q <= OWN_IF;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/bus_mux_sequencer.sv
// rtl/bus_mux_sequencer.sv - IF/DM arbitration and address/data phase sequencing for the MUX16 bus
module bus_mux_sequencer
    import bus_seq_pkg::*;
#(
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned AddrWidth     = 24,
    parameter int unsigned TimeoutCycles = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned CntWidth      = DEFAULT_CNT_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 if_req,
    input  logic [AddrWidth-1:0] if_addr,
    output logic                 if_gnt,
    output logic                 if_done,
    input  logic                 dm_req,
    input  logic                 dm_we,
    input  logic [AddrWidth-1:0] dm_addr,
    input  logic [DataWidth-1:0] dm_wdata,
    output logic                 dm_gnt,
    output logic                 dm_done,
    output logic [DataWidth-1:0] rdata,
    output logic                 err,
    output logic [AddrWidth-1:0] mux_addr,
    output logic [DataWidth-1:0] mux_data,
    output logic                 mux_select,
    output logic                 bus_ale,
    output logic                 bus_oe,
    output logic                 bus_we,
    input  logic                 bus_ready,
    input  logic [DataWidth-1:0] bus_rdata
);

    // Last DATA-phase count at which a missing bus_ready aborts the transfer.
    localparam logic [CntWidth-1:0] CNT_LAST = CntWidth'(TimeoutCycles - 1);

    state_e                 state_q, state_d;
    owner_e                 owner_q, owner_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [DataWidth-1:0]   wdata_q, wdata_d;
    logic                   we_q, we_d;
    logic [CntWidth-1:0]    cnt_q, cnt_d;
    logic [DataWidth-1:0]   rdata_q, rdata_d;
    logic                   if_done_q, if_done_d;
    logic                   dm_done_q, dm_done_d;
    logic                   err_q, err_d;
    logic [1:0]             arb_gnt;
    logic                   arb_update;

    rr_arb2 u_arb (
        .clock  (clock),
        .reset  (reset),
        .req    ({dm_req, if_req}),
        .update (arb_update),
        .gnt    (arb_gnt)
    );

    // Next-state and transfer-register logic; done/err pulse only on the DATA->IDLE step.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        if_done_d  = 1'b0;
        dm_done_d  = 1'b0;
        err_d      = 1'b0;
        arb_update = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_gnt != 2'b00) begin
                    arb_update = 1'b1;
                    state_d    = ST_ADDR;
                    if (arb_gnt[1]) begin
                        owner_d = OWN_DM;
                        addr_d  = dm_addr;
                        we_d    = dm_we;
                        wdata_d = dm_wdata;
                    end else begin
                        // Fetches never write, so the data register is cleared for them.
                        owner_d = OWN_IF;
                        addr_d  = if_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                    end
                end
            end
            ST_ADDR: begin
                cnt_d   = '0;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bus_ready || (cnt_q == CNT_LAST)) begin
                    state_d   = ST_IDLE;
                    if_done_d = (owner_q == OWN_IF);
                    dm_done_d = (owner_q == OWN_DM);
                    // A ready in the final allowed cycle still counts as a normal completion.
                    if (bus_ready) begin
                        if (!we_q) begin
                            rdata_d = bus_rdata;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Transfer, wait-counter and result registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner_q   <= OWN_IF;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            if_done_q <= 1'b0;
            dm_done_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            if_done_q <= if_done_d;
            dm_done_q <= dm_done_d;
            err_q     <= err_d;
        end
    end

    // Bus strobes are pure state decodes, so reset silences them in the same cycle.
    assign if_gnt     = ((state_q == ST_ADDR) || (state_q == ST_DATA)) && (owner_q == OWN_IF);
    assign dm_gnt     = ((state_q == ST_ADDR) || (state_q == ST_DATA)) && (owner_q == OWN_DM);
    assign bus_ale    = (state_q == ST_ADDR);
    assign mux_select = (state_q == ST_DATA);
    assign bus_oe     = (state_q == ST_ADDR) || ((state_q == ST_DATA) && we_q);
    assign bus_we     = (state_q == ST_DATA) && we_q;
    assign mux_addr   = addr_q;
    assign mux_data   = wdata_q;
    assign rdata      = rdata_q;
    assign if_done    = if_done_q;
    assign dm_done    = dm_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_bus_mux_sequencer.sv
// tb/tb_bus_mux_sequencer.sv - self-checking bench for bus_mux_sequencer
module tb_bus_mux_sequencer;

    localparam int TO = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req;
    logic [23:0] if_addr;
    logic        if_gnt;
    logic        if_done;
    logic        dm_req;
    logic        dm_we;
    logic [23:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_done;
    logic [31:0] rdata;
    logic        err;
    logic [23:0] mux_addr;
    logic [31:0] mux_data;
    logic        mux_select;
    logic        bus_ale;
    logic        bus_oe;
    logic        bus_we;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_rdata;

    bus_mux_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_done    (if_done),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_gnt     (dm_gnt),
        .dm_done    (dm_done),
        .rdata      (rdata),
        .err        (err),
        .mux_addr   (mux_addr),
        .mux_data   (mux_data),
        .mux_select (mux_select),
        .bus_ale    (bus_ale),
        .bus_oe     (bus_oe),
        .bus_we     (bus_we),
        .bus_ready  (bus_ready),
        .bus_rdata  (bus_rdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        who;
        logic        we;
        logic [23:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        int          waits;
        int          exp_done;
        logic        exp_err;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // {if_gnt, dm_gnt, if_done, dm_done, err, ale, oe, we, select}
    function automatic logic [8:0] flags();
        return {if_gnt, dm_gnt, if_done, dm_done, err, bus_ale, bus_oe, bus_we, mux_select};
    endfunction

    function automatic logic [8:0] f_addr(input logic who);
        return {~who, who, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0};
    endfunction

    function automatic logic [8:0] f_data(input logic who, input logic we);
        return {~who, who, 3'b000, 1'b0, we, we, 1'b1};
    endfunction

    function automatic logic [8:0] f_done(input logic who, input logic e);
        return {2'b00, ~who, who, e, 4'b0000};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One complete transfer from a single requester; the cycle-by-cycle expectations follow
    // from the phase rules: ADDR at cycle 1, DATA from cycle 2 until ready/timeout, done next.
    task automatic xfer(input logic who, input logic we, input logic [23:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int waits,
                        input int exp_done, input logic exp_err);
        logic [31:0] exp_md;
        exp_md = who ? wd : 32'h0;
        if (who) begin
            dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        bus_ready = 1'b0;
        tick();
        check("addr_flags", 32'(flags()), 32'(f_addr(who)));
        check("addr_mux_addr", 32'(mux_addr), 32'(a));
        check("addr_mux_data", mux_data, exp_md);
        if_addr = ~a; dm_addr = ~a; dm_wdata = ~wd; dm_we = ~we;
        for (int c = 2; c < exp_done; c++) begin
            tick();
            check("data_flags", 32'(flags()), 32'(f_data(who, we)));
            check("data_mux_addr", 32'(mux_addr), 32'(a));
            check("data_mux_data", mux_data, exp_md);
            check("data_rdata_hold", rdata, exp_rdata);
            bus_ready = ((c - 2) == waits);
            bus_rdata = ((c - 2) == waits) ? rd : $urandom;
        end
        tick();
        bus_ready = 1'b0;
        if (!exp_err && !we) exp_rdata = rd;
        check("done_flags", 32'(flags()), 32'(f_done(who, exp_err)));
        check("done_rdata", rdata, exp_rdata);
        check("done_mux_addr_hold", 32'(mux_addr), 32'(a));
        if_req = 1'b0;
        dm_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        who, we;
        int          waits;
        logic [31:0] rnd;

        tbl[0] = '{1'b0, 1'b0, 24'h000100, 32'h0,        32'hDEADBEEF, 0,  3,  1'b0};
        tbl[1] = '{1'b1, 1'b1, 24'h00ABCD, 32'h12345678, 32'hBAD0BAD0, 2,  5,  1'b0};
        tbl[2] = '{1'b1, 1'b0, 24'h000040, 32'h0,        32'hCAFEF00D, 16, 18, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 24'h0FFFFF, 32'h0,        32'h55AA55AA, 15, 18, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 24'hFFFFFF, 32'h0,        32'hA5A5A5A5, 1,  4,  1'b0};
        tbl[5] = '{1'b0, 1'b0, 24'h000000, 32'h0,        32'h01020304, 16, 18, 1'b1};

        reset = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = '0; dm_wdata = '0; bus_ready = 1'b0; bus_rdata = '0;
        exp_rdata = '0;
        tick();
        check("reset_flags", 32'(flags()), 32'h0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_mux_addr", 32'(mux_addr), 32'h0);
        check("reset_mux_data", mux_data, 32'h0);
        reset = 1'b0;
        tick();

        // Simultaneous requests held high: DM first after reset, then strict alternation.
        if_addr = 24'h111111; dm_addr = 24'h222222; dm_we = 1'b0;
        bus_rdata = 32'h77777777; bus_ready = 1'b1;
        if_req = 1'b1; dm_req = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            logic o;
            tick();
            o = (((c - 1) / 3) % 2) == 0;
            case ((c - 1) % 3)
                0: begin
                    check("arb_addr_flags", 32'(flags()), 32'(f_addr(o)));
                    check("arb_mux_addr", 32'(mux_addr), o ? 32'h222222 : 32'h111111);
                end
                1: check("arb_data_flags", 32'(flags()), 32'(f_data(o, 1'b0)));
                default: check("arb_done_flags", 32'(flags()), 32'(f_done(o, 1'b0)));
            endcase
        end
        if_req = 1'b0; dm_req = 1'b0; bus_ready = 1'b0;
        exp_rdata = 32'h77777777;
        tick();
        check("arb_idle_flags", 32'(flags()), 32'h0);
        check("arb_rdata", rdata, exp_rdata);

        // Table-driven directed transfers.
        for (int i = 0; i < 6; i++) begin
            xfer(tbl[i].who, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rd,
                 tbl[i].waits, tbl[i].exp_done, tbl[i].exp_err);
        end

        // Random single-requester transfers against the transaction-level model.
        for (int n = 0; n < 25; n++) begin
            who   = 1'($urandom_range(0, 1));
            we    = who ? 1'($urandom_range(0, 1)) : 1'b0;
            waits = $urandom_range(0, 19);
            rnd   = $urandom;
            xfer(who, we, rnd[23:0], $urandom, $urandom, waits,
                 (waits >= TO) ? (2 + TO) : (3 + waits), (waits >= TO));
        end
        tick();

        // Reset in the middle of a DM read's DATA phase.
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 24'h001234; bus_ready = 1'b0;
        tick();
        check("rst_pre_addr_flags", 32'(flags()), 32'(f_addr(1'b1)));
        tick();
        check("rst_pre_data_flags", 32'(flags()), 32'(f_data(1'b1, 1'b0)));
        #1 reset = 1'b1;
        #1;
        exp_rdata = '0;
        check("rst_mid_flags", 32'(flags()), 32'h0);
        check("rst_mid_rdata", rdata, exp_rdata);
        check("rst_mid_mux_addr", 32'(mux_addr), 32'h0);
        tick();
        check("rst_hold_flags", 32'(flags()), 32'h0);
        reset = 1'b0;
        tick();
        check("rst_after_addr_flags", 32'(flags()), 32'(f_addr(1'b1)));
        check("rst_after_mux_addr", 32'(mux_addr), 32'h001234);
        tick();
        check("rst_after_data_flags", 32'(flags()), 32'(f_data(1'b1, 1'b0)));
        bus_ready = 1'b1; bus_rdata = 32'h0BADF00D;
        tick();
        bus_ready = 1'b0; dm_req = 1'b0;
        exp_rdata = 32'h0BADF00D;
        check("rst_after_done_flags", 32'(flags()), 32'(f_done(1'b1, 1'b0)));
        check("rst_after_rdata", rdata, exp_rdata);
        tick();
        check("final_idle_flags", 32'(flags()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
